// File: rtl/lsq_mem_sched_if.sv
// Bundle of LSQ-side request/response and data-memory port signals for lsq_mem_sched.
// slave = scheduler side, master = LSQ/memory environment side.
interface lsq_mem_sched_if;
  // load issue path
  logic        ld_valid;
  logic [31:0] ld_pc;
  logic [31:0] ld_addr;
  logic        ld_ready;
  // retired-store drain path
  logic        st_valid;
  logic [31:0] st_pc;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  // data-memory port
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  // completions and status
  logic        ld_resp_valid;
  logic [31:0] ld_resp_pc;
  logic [31:0] ld_resp_data;
  logic        st_done;
  logic [31:0] st_done_pc;
  logic        busy;
  logic        mem_err;

  modport slave (
    input  ld_valid, ld_pc, ld_addr,
    output ld_ready,
    input  st_valid, st_pc, st_addr, st_data,
    output st_ready,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output ld_resp_valid, ld_resp_pc, ld_resp_data,
    output st_done, st_done_pc, busy, mem_err
  );

  modport master (
    output ld_valid, ld_pc, ld_addr,
    input  ld_ready,
    output st_valid, st_pc, st_addr, st_data,
    input  st_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  ld_resp_valid, ld_resp_pc, ld_resp_data,
    input  st_done, st_done_pc, busy, mem_err
  );
endinterface

// File: rtl/lsq_mem_sched.sv
// lsq_mem_sched: single data-memory port scheduler for LSQ loads and retired-store drain.
// One outstanding transaction, IDLE -> ISSUE -> (WAIT) -> IDLE.
// Optional watchdog: define MEM_TIMEOUT_EN to abort transactions stuck for TIMEOUT cycles.
module lsq_mem_sched #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input logic            clk,
  input logic            rstn,
  lsq_mem_sched_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t         state;
  logic [SW-1:0]  starve_cnt;
  logic           op_we;
  logic [31:0]    lat_pc, lat_addr, lat_data;
  logic           ld_resp_valid, st_done;
  logic [31:0]    ld_resp_pc, ld_resp_data, st_done_pc;
  logic           same_word, starved, grant_st, grant_ld;
  logic           tmo_fire;
  logic           err_q;

  // Arbitration: same-word store first (keeps RAW order), then a starved load, then store, then load.
  always_comb begin
    same_word = bus.ld_valid && bus.st_valid && (bus.ld_addr[31:2] == bus.st_addr[31:2]);
    starved   = bus.ld_valid && (starve_cnt == SW'(STARVE_LIMIT));
    grant_st  = (state == IDLE) && bus.st_valid && (same_word || !starved);
    grant_ld  = (state == IDLE) && bus.ld_valid && !grant_st;
  end

  assign bus.ld_ready      = grant_ld;
  assign bus.st_ready      = grant_st;
  assign bus.mem_req       = (state == ISSUE);
  assign bus.mem_we        = op_we;
  assign bus.mem_addr      = lat_addr;
  assign bus.mem_wdata     = lat_data;
  assign bus.ld_resp_valid = ld_resp_valid;
  assign bus.ld_resp_pc    = ld_resp_pc;
  assign bus.ld_resp_data  = ld_resp_data;
  assign bus.st_done       = st_done;
  assign bus.st_done_pc    = st_done_pc;
  assign bus.busy          = (state != IDLE);
  assign bus.mem_err       = err_q;

`ifdef MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;

  // A normal completion in the final cycle beats the watchdog.
  assign tmo_fire = (state != IDLE) && (tmo_cnt == TW'(TIMEOUT - 1)) &&
                    !((state == WAIT) && bus.mem_rvalid) &&
                    !((state == ISSUE) && bus.mem_gnt && op_we);

  // Cycles spent in ISSUE+WAIT; held at zero in IDLE so each transaction starts fresh.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)               tmo_cnt <= '0;
    else if (state == IDLE)  tmo_cnt <= '0;
    else                     tmo_cnt <= tmo_cnt + TW'(1);
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         err_q <= 1'b0;
    else if (tmo_fire) err_q <= 1'b1;
  end
`else
  assign tmo_fire = 1'b0;
  assign err_q    = 1'b0;
`endif

  // Starvation counter: store grants that passed over a pending load.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (grant_ld || !bus.ld_valid)
        starve_cnt <= '0;
      else if (grant_st && (starve_cnt != SW'(STARVE_LIMIT)))
        starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // Transaction FSM with request latches and registered completion pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      op_we         <= 1'b0;
      lat_pc        <= '0;
      lat_addr      <= '0;
      lat_data      <= '0;
      ld_resp_valid <= 1'b0;
      ld_resp_pc    <= '0;
      ld_resp_data  <= '0;
      st_done       <= 1'b0;
      st_done_pc    <= '0;
    end else begin
      ld_resp_valid <= 1'b0;
      st_done       <= 1'b0;
      if (tmo_fire) begin
        state <= IDLE;
        if (op_we) begin
          st_done    <= 1'b1;
          st_done_pc <= lat_pc;
        end else begin
          ld_resp_valid <= 1'b1;
          ld_resp_pc    <= lat_pc;
          ld_resp_data  <= 32'hDEAD_BEEF;
        end
      end else begin
        case (state)
          IDLE: begin
            if (grant_st) begin
              op_we    <= 1'b1;
              lat_pc   <= bus.st_pc;
              lat_addr <= bus.st_addr;
              lat_data <= bus.st_data;
              state    <= ISSUE;
            end else if (grant_ld) begin
              op_we    <= 1'b0;
              lat_pc   <= bus.ld_pc;
              lat_addr <= bus.ld_addr;
              lat_data <= '0;
              state    <= ISSUE;
            end
          end
          ISSUE: begin
            if (bus.mem_gnt) begin
              if (op_we) begin
                st_done    <= 1'b1;
                st_done_pc <= lat_pc;
                state      <= IDLE;
              end else begin
                state <= WAIT;
              end
            end
          end
          WAIT: begin
            if (bus.mem_rvalid) begin
              ld_resp_valid <= 1'b1;
              ld_resp_pc    <= lat_pc;
              ld_resp_data  <= bus.mem_rdata;
              state         <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_lsq_mem_sched.sv
// Scoreboard bench for lsq_mem_sched: expected grant order and completions are queued
// as stimulus is driven and checked when the scheduler produces them.
module tb_lsq_mem_sched;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  lsq_mem_sched_if bus();

  lsq_mem_sched #(.STARVE_LIMIT(4), .TIMEOUT(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ld_exp_t;

  ld_exp_t     ld_q[$];
  logic [31:0] st_q[$];
  logic [7:0]  gnt_q[$];

  int total = 0;
  int bad   = 0;
  int gnt_dly = 0;
  int rv_dly  = 0;
  bit mem_mute = 1'b0;

  localparam logic [7:0] GS = 8'h53;  // 'S'
  localparam logic [7:0] GL = 8'h4C;  // 'L'

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memval(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0000_CAFE : (a ^ 32'hA5A5_0000);
  endfunction

  // Monitor: grants against expected order, completions against queued expectations.
  logic [7:0] g_exp;
  ld_exp_t    l_exp;
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.ld_ready || bus.st_ready) begin
        chk("gnt_excl", {31'd0, bus.ld_ready & bus.st_ready}, 32'd0);
        if (gnt_q.size() == 0) begin
          chk("gnt_unexp", {30'd0, bus.ld_ready, bus.st_ready}, 32'd0);
        end else begin
          g_exp = gnt_q.pop_front();
          chk("gnt_order", {24'd0, (bus.st_ready ? GS : GL)}, {24'd0, g_exp});
        end
        if (bus.st_ready) st_q.push_back(bus.st_pc);
        if (bus.ld_ready)
          ld_q.push_back('{bus.ld_pc, (mem_mute ? 32'hDEAD_BEEF : memval(bus.ld_addr))});
      end
      if (bus.st_done) begin
        if (st_q.size() == 0) chk("st_spur", {31'd0, bus.st_done}, 32'd0);
        else chk("st_done_pc", bus.st_done_pc, st_q.pop_front());
      end
      if (bus.ld_resp_valid) begin
        if (ld_q.size() == 0) begin
          chk("ld_spur", {31'd0, bus.ld_resp_valid}, 32'd0);
        end else begin
          l_exp = ld_q.pop_front();
          chk("ld_resp_pc", bus.ld_resp_pc, l_exp.pc);
          chk("ld_resp_data", bus.ld_resp_data, l_exp.data);
        end
      end
    end
  end

  // Memory model: grant after gnt_dly cycles, read data rv_dly cycles after grant.
  logic        r_we;
  logic [31:0] r_a;
  initial begin
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req && !mem_mute) begin
        repeat (gnt_dly) @(negedge clk);
        r_we = bus.mem_we;
        r_a  = bus.mem_addr;
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        if (!r_we) begin
          repeat (rv_dly) @(negedge clk);
          bus.mem_rdata  = memval(r_a);
          bus.mem_rvalid = 1'b1;
          @(negedge clk);
          bus.mem_rvalid = 1'b0;
        end
      end
    end
  end

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((bus.busy || ld_q.size() != 0 || st_q.size() != 0) && n < max);
    chk(tag, {31'd0, bus.busy} + ld_q.size() + st_q.size(), 32'd0);
  endtask

  task automatic wait_grants(input int n, input string tag);
    int g = 0;
    int c = 0;
    while (g < n && c < 100) begin
      @(negedge clk);
      c++;
      if (bus.ld_ready || bus.st_ready) g++;
    end
    chk(tag, g, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=stuck exp=finish");
    $fatal(1, "bench watchdog");
  end

  initial begin
    bus.ld_valid = 1'b0; bus.ld_pc = '0; bus.ld_addr = '0;
    bus.st_valid = 1'b0; bus.st_pc = '0; bus.st_addr = '0; bus.st_data = '0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_req", {31'd0, bus.mem_req}, 0);
    chk("rst_ldv", {31'd0, bus.ld_resp_valid}, 0);
    chk("rst_std", {31'd0, bus.st_done}, 0);
    chk("rst_err", {31'd0, bus.mem_err}, 0);
    chk("rst_lddata", bus.ld_resp_data, 0);
    chk("rst_stpc", bus.st_done_pc, 0);
    @(posedge clk); #1 rstn = 1'b1;

    // lone load, immediate grant, data two cycles later
    gnt_dly = 0; rv_dly = 2;
    gnt_q.push_back(GL);
    @(posedge clk); #1;
    bus.ld_valid = 1'b1; bus.ld_pc = 32'h10; bus.ld_addr = 32'h100;
    @(negedge clk);
    chk("t1_ld_ready", {31'd0, bus.ld_ready}, 1);
    @(posedge clk); #1 bus.ld_valid = 1'b0;
    @(negedge clk);
    chk("t1_req", {31'd0, bus.mem_req}, 1);
    chk("t1_we", {31'd0, bus.mem_we}, 0);
    chk("t1_addr", bus.mem_addr, 32'h100);
    chk("t1_ready_1cyc", {31'd0, bus.ld_ready}, 0);
    wait_idle("t1_idle", 20);
    repeat (3) @(negedge clk);
    chk("t1_hold", bus.ld_resp_data, 32'hCAFE);

    // lone store, grant delayed 3 cycles: request held stable 4 cycles
    gnt_dly = 3;
    gnt_q.push_back(GS);
    @(posedge clk); #1;
    bus.st_valid = 1'b1; bus.st_pc = 32'h20; bus.st_addr = 32'h200; bus.st_data = 32'h55;
    @(negedge clk);
    chk("t2_st_ready", {31'd0, bus.st_ready}, 1);
    @(posedge clk); #1 bus.st_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_req", {31'd0, bus.mem_req}, 1);
      chk("t2_we", {31'd0, bus.mem_we}, 1);
      chk("t2_addr", bus.mem_addr, 32'h200);
      chk("t2_wdata", bus.mem_wdata, 32'h55);
    end
    @(negedge clk);
    chk("t2_req_drop", {31'd0, bus.mem_req}, 0);
    wait_idle("t2_idle", 20);
    chk("t2_hold", bus.st_done_pc, 32'h20);

    // both held, distinct addresses: S,S,S,S,L repeated
    gnt_dly = 0; rv_dly = 0;
    for (int r = 0; r < 2; r++) begin
      repeat (4) gnt_q.push_back(GS);
      gnt_q.push_back(GL);
    end
    @(posedge clk); #1;
    bus.ld_valid = 1'b1; bus.ld_pc = 32'h30; bus.ld_addr = 32'h300;
    bus.st_valid = 1'b1; bus.st_pc = 32'h40; bus.st_addr = 32'h400; bus.st_data = 32'h77;
    wait_grants(10, "t3_grants");
    @(posedge clk); #1;
    bus.ld_valid = 1'b0; bus.st_valid = 1'b0;
    wait_idle("t3_idle", 30);

    // same word while the load is starved: store still first, then load
    repeat (5) gnt_q.push_back(GS);
    gnt_q.push_back(GL);
    @(posedge clk); #1;
    bus.ld_valid = 1'b1; bus.ld_pc = 32'h50; bus.ld_addr = 32'h104;
    bus.st_valid = 1'b1; bus.st_pc = 32'h60; bus.st_addr = 32'h500; bus.st_data = 32'h11;
    wait_grants(4, "t4_pre");
    @(posedge clk); #1;
    bus.st_pc = 32'h64; bus.st_addr = 32'h104; bus.st_data = 32'h22;
    wait_grants(1, "t4_raw_st");
    @(posedge clk); #1 bus.st_valid = 1'b0;
    wait_grants(1, "t4_ld");
    @(posedge clk); #1 bus.ld_valid = 1'b0;
    wait_idle("t4_idle", 30);

    // reset while in WAIT; late rvalid must be ignored
    gnt_dly = 0; rv_dly = 6;
    gnt_q.push_back(GL);
    @(posedge clk); #1;
    bus.ld_valid = 1'b1; bus.ld_pc = 32'h70; bus.ld_addr = 32'h700;
    @(negedge clk);
    chk("t5_ld_ready", {31'd0, bus.ld_ready}, 1);
    @(posedge clk); #1 bus.ld_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_wait_busy", {31'd0, bus.busy}, 1);
    chk("t5_wait_req", {31'd0, bus.mem_req}, 0);
    @(posedge clk); #1 rstn = 1'b0;
    ld_q.delete();
    @(negedge clk);
    chk("t5_rst_busy", {31'd0, bus.busy}, 0);
    chk("t5_rst_ldv", {31'd0, bus.ld_resp_valid}, 0);
    chk("t5_rst_data", bus.ld_resp_data, 0);
    chk("t5_rst_pc", bus.ld_resp_pc, 0);
    chk("t5_rst_stpc", bus.st_done_pc, 0);
    @(posedge clk); #1 rstn = 1'b1;
    repeat (12) @(negedge clk);
    chk("t5_after_busy", {31'd0, bus.busy}, 0);
    chk("t5_after_data", bus.ld_resp_data, 0);
    rv_dly = 1;
    gnt_q.push_back(GL);
    @(posedge clk); #1;
    bus.ld_valid = 1'b1; bus.ld_pc = 32'h80; bus.ld_addr = 32'h800;
    @(negedge clk);
    chk("t5_next_ready", {31'd0, bus.ld_ready}, 1);
    @(posedge clk); #1 bus.ld_valid = 1'b0;
    wait_idle("t5_next_idle", 20);

`ifdef MEM_TIMEOUT_EN
    // load that is never granted: watchdog after 8 cycles
    mem_mute = 1'b1;
    gnt_q.push_back(GL);
    @(posedge clk); #1;
    bus.ld_valid = 1'b1; bus.ld_pc = 32'h90; bus.ld_addr = 32'h900;
    @(negedge clk);
    chk("to_ld_ready", {31'd0, bus.ld_ready}, 1);
    @(posedge clk); #1 bus.ld_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("to_req_hold", {31'd0, bus.mem_req}, 1);
    chk("to_err_pre", {31'd0, bus.mem_err}, 0);
    @(negedge clk);
    chk("to_req_drop", {31'd0, bus.mem_req}, 0);
    chk("to_err", {31'd0, bus.mem_err}, 1);
    chk("to_busy", {31'd0, bus.busy}, 0);
    chk("to_data", bus.ld_resp_data, 32'hDEAD_BEEF);
    mem_mute = 1'b0;
    repeat (3) @(negedge clk);
    chk("to_err_sticky", {31'd0, bus.mem_err}, 1);
`else
    chk("mem_err_tied", {31'd0, bus.mem_err}, 0);
`endif

    repeat (3) @(negedge clk);
    chk("end_gnt_q", gnt_q.size(), 0);
    chk("end_ld_q", ld_q.size(), 0);
    chk("end_st_q", st_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lsq_mem_sched.md
Name: lsq_mem_sched

Overview:
Scheduler for the single data-memory port shared by the load-store queue's load issue path and the retired-store drain path. It arbitrates between one load requester and one store requester and sequences a single outstanding memory transaction through a request/grant/response FSM. It returns load data, tagged with the instruction PC, to the LSQ/writeback side, and pulses store completion to the retirement side.

Parameters:
STARVE_LIMIT, 4, consecutive store grants allowed while a load is pending before the load is forced.
TIMEOUT, 64, cycles allowed in ISSUE+WAIT before watchdog fires (only with MEM_TIMEOUT_EN).

Ports:
clk  in  1  clock, all state on rising edge
rstn  in  1  asynchronous active-low reset
ld_valid  in  1  load request pending
ld_pc  in  32  load instruction PC (tag)
ld_addr  in  32  load effective address
ld_ready  out  1  load request accepted this cycle (combinational)
st_valid  in  1  retired store pending
st_pc  in  32  store instruction PC
st_addr  in  32  store address
st_data  in  32  store data
st_ready  out  1  store request accepted this cycle (combinational)
mem_req  out  1  memory request
mem_we  out  1  1 = write, 0 = read
mem_addr  out  32  memory address
mem_wdata  out  32  write data
mem_gnt  in  1  memory accepted request
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read data
ld_resp_valid  out  1  one-cycle pulse, load data returned
ld_resp_pc  out  32  PC of returned load
ld_resp_data  out  32  returned load data
st_done  out  1  one-cycle pulse, store written
st_done_pc  out  32  PC of completed store
busy  out  1  FSM not in IDLE
mem_err  out  1  sticky watchdog flag (0 without MEM_TIMEOUT_EN)

Behaviour:
- Reset (rstn low, async): FSM=IDLE; starvation counter=0; all latches, outputs, pulses=0; mem_err=0. Reset mid-transaction abandons it with no response pulse; late mem_gnt/mem_rvalid after reset are ignored in IDLE.
- States: IDLE, ISSUE, WAIT.
- IDLE: ld_ready/st_ready driven only here; at most one high per cycle. Winner's pc/addr/data/op latched at clock edge; go ISSUE. No request: stay IDLE.
- Arbitration priority: (1) both valid and ld_addr[31:2]==st_addr[31:2] -> store wins (RAW ordering), overriding starvation; (2) load pending and starve_cnt==STARVE_LIMIT -> load; (3) store; (4) load.
- starve_cnt (width clog2(STARVE_LIMIT+1)): +1 on store grant while ld_valid high, saturating at STARVE_LIMIT; cleared on any load grant or any IDLE cycle with ld_valid low.
- ISSUE: mem_req=1, mem_we/addr/wdata from latches, held stable until mem_gnt. On mem_gnt: store -> st_done=1 and st_done_pc=latched PC next cycle, go IDLE; load -> WAIT.
- WAIT: mem_req=0. On mem_rvalid: ld_resp_valid=1, ld_resp_pc, ld_resp_data=mem_rdata registered (pulse next cycle); go IDLE. mem_rvalid outside WAIT ignored.
- Throughput: store 2 cycles min (IDLE+ISSUE w/ immediate gnt); load 3 cycles min. Next request can be accepted in the IDLE cycle concurrent with the response pulse.
- ld_resp_pc/data and st_done_pc hold last value between pulses.
- busy = (state != IDLE).

Optional Feature:
MEM_TIMEOUT_EN: when defined, a counter runs in ISSUE/WAIT and resets on entering ISSUE; at TIMEOUT cycles: mem_err sets (sticky until reset), mem_req drops, the load response pulses with data 32'hDEAD_BEEF (or st_done pulses for a store), and the FSM returns to IDLE. When undefined, no counter exists, the FSM waits indefinitely, and mem_err is tied 0.

Test Plan:
- Lone load pc=0x10 addr=0x100, gnt immediate, rvalid 2 cycles later with 0xCAFE -> ld_ready 1 cycle, mem_we=0, ld_resp_valid pulse with pc=0x10, data=0xCAFE.
- Lone store pc=0x20 addr=0x200 data=0x55, gnt delayed 3 cycles -> mem_req/addr/wdata stable 4 cycles; st_done pulse, st_done_pc=0x20.
- ld_valid and st_valid held continuously, different addresses, STARVE_LIMIT=4 -> grant order S,S,S,S,L,S,S,S,S,L.
- Load addr 0x104 and store addr 0x104 simultaneously while starve_cnt==STARVE_LIMIT -> store granted first, then load.
- rstn low while in WAIT, then rvalid after release -> no ld_resp_valid; all outputs 0; next request is serviced normally.
- MEM_TIMEOUT_EN, TIMEOUT=8, load with no gnt -> after 8 cycles mem_err=1, ld_resp_data=0xDEADBEEF, FSM in IDLE.
